uart_tx_peripheral: RTL and testbench

UART_TX_PERIPHERAL -- requirements
Module: uart_tx_peripheral

---
 rtl/uart_tx_peripheral_pkg.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 83 ++++++++
 rtl/uart_tx_peripheral.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_peripheral.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_peripheral_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_peripheral_pkg
//  Purpose  : Shared definitions for the CPU memory/branch decode and the UART
//             transmit peripheral: status bit positions, transmitter FSM
//             state encodings and a helper that packs the status word.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_peripheral_pkg;

    // Memory access size encodings used by the load/store unit.
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    // Branch condition encodings used by the branch unit.
    localparam logic [2:0] BRANCH_NONE = 3'd0;
    localparam logic [2:0] BRANCH_EQ   = 3'd1;
    localparam logic [2:0] BRANCH_NE   = 3'd2;
    localparam logic [2:0] BRANCH_LT   = 3'd3;
    localparam logic [2:0] BRANCH_GE   = 3'd4;

    // UART status word bit positions.
    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_BUSY_BIT     = 2;
    localparam int STATUS_OVERFLOW_BIT = 3;

    // UART transmitter FSM state encodings.
    localparam int         TX_STATE_W = 2;
    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_START   = 2'd1;
    localparam logic [1:0] TX_DATA    = 2'd2;
    localparam logic [1:0] TX_STOP    = 2'd3;

    // Pack the status flags into the 32-bit CPU-visible word; upper bits zero.
    function automatic logic [31:0] build_status(
        input logic full,
        input logic empty,
        input logic busy,
        input logic overflow
    );
        logic [31:0] s;
        s                      = '0;
        s[STATUS_FULL_BIT]     = full;
        s[STATUS_EMPTY_BIT]    = empty;
        s[STATUS_BUSY_BIT]     = busy;
        s[STATUS_OVERFLOW_BIT] = overflow;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO feeding the UART transmitter. A push into a full FIFO
//             is accepted only when a pop happens in the same cycle.
//  Ports    : clock, reset      - clock, synchronous active-high reset
//             push_i, push_data_i - write strobe and byte
//             pop_i             - remove head (ignored when empty)
//             pop_data_o        - current head byte
//             count_o           - occupancy, 0..FIFO_DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [7:0]                    push_data_i,
    input  logic                          pop_i,
    output logic [7:0]                    pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (count_q == '0);
    assign w_do_pop  = pop_i && !w_empty;
    // A slot freed by a same-cycle pop may be reused immediately.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clock) begin
        if (!reset && w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_peripheral
//  Purpose  : Memory-mapped 8N1 UART transmitter with a small byte FIFO and a
//             sticky overflow flag.
//  Ports    : clock, reset     - CPU clock, synchronous active-high reset
//             wr_en, wr_data   - store strobe and byte to transmit
//             clear_overflow   - clears the sticky overflow flag
//             status[31:0]     - [0] full [1] empty [2] busy [3] overflow
//             tx               - registered serial line, idle high
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_peripheral
    import uart_tx_peripheral_pkg::*;
#(
    parameter int CLKS_PER_BIT = 469,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clear_overflow,
    output logic [31:0] status,
    output logic        tx
);

    localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [TX_STATE_W-1:0] state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  overflow_q, overflow_d;

    logic [7:0]            w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_bit_end;
    logic                  w_pop;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .count_o     (w_count)
    );

    assign w_full    = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (w_count == '0);
    assign w_bit_end = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // State register (together with the datapath registers it steers)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (!w_empty) begin
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_bit_end && (bit_q == 3'd7)) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                // Back-to-back frames: go straight to a new start bit.
                if (w_bit_end) begin
                    state_d = w_empty ? TX_IDLE : TX_START;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_pop      = 1'b0;
        baud_d     = (w_bit_end || (state_q == TX_IDLE)) ? '0 : baud_q + BAUD_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        case (state_q)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                // The shift register is drained LSB first.
                if (w_bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    // The 3-bit index wraps to zero only on the last data bit.
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (w_bit_end && !w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    tx_d    = 1'b0;
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_en && w_full && !w_pop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign status = build_status(w_full, w_empty, (state_q != TX_IDLE), overflow_q);
    assign tx     = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_peripheral
//  Purpose  : Self-checking bench for uart_tx_peripheral (CLKS_PER_BIT=4,
//             FIFO_DEPTH=4). A frame-level reference model predicts tx and
//             status for every cycle; directed scenarios plus random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_peripheral;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clear_overflow;
    logic [31:0] status;
    logic        tx;

    int tests = 0;
    int fails = 0;

    // Reference model: queued bytes, byte on the wire, cycles left in frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_left;
    logic       m_ovf;

    uart_tx_peripheral #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .clear_overflow (clear_overflow),
        .status         (status),
        .tx             (tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge(input logic rst, input logic wr, input logic [7:0] d,
                              input logic clr);
        logic pop;
        logic full;
        if (rst) begin
            m_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            return;
        end
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && (m_left <= 1);
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
        if (wr && (!full || pop)) m_q.push_back(d);
        if (wr && full && !pop) m_ovf = 1'b1;
        else if (clr)           m_ovf = 1'b0;
    endtask

    function automatic logic exp_tx();
        int pos;
        int b;
        if (m_left == 0) return 1'b1;
        pos = FRAME - m_left;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (m_q.size() == DEPTH);
        s[1] = (m_q.size() == 0);
        s[2] = (m_left != 0);
        s[3] = m_ovf;
        return s;
    endfunction

    task automatic check_outputs();
        logic        et;
        logic [31:0] es;
        et = exp_tx();
        es = exp_status();
        tests++;
        assert (tx === et) else begin
            fails++;
            $error("FAIL tx @%0t: observed %0b expected %0b", $time, tx, et);
        end
        tests++;
        assert (status === es) else begin
            fails++;
            $error("FAIL status @%0t: observed %08h expected %08h", $time, status, es);
        end
    endtask

    // Drive inputs, take one edge, update model, sample 1 time unit later.
    task automatic step(input logic rst, input logic wr, input logic [7:0] d,
                        input logic clr);
        reset          = rst;
        wr_en          = wr;
        wr_data        = d;
        clear_overflow = clr;
        @(posedge clock);
        model_edge(rst, wr, d, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic write(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        clear_overflow = 1'b0;
        m_left         = 0;
        m_ovf          = 1'b0;
        m_cur          = 8'h00;

        // Reset, with a write in the reset cycle that must be ignored.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        tests++;
        assert (status === 32'h0000_0002) else begin
            fails++;
            $error("FAIL reset_status: observed %08h expected 00000002", status);
        end
        idle(3);

        // Single frame 0x55.
        write(8'h55);
        idle(1);
        tests++;
        assert (tx === 1'b0) else begin
            fails++;
            $error("FAIL start_latency: observed %0b expected 0", tx);
        end
        idle(FRAME + 4);
        tests++;
        assert (status === 32'h0000_0002) else begin
            fails++;
            $error("FAIL after_frame_status: observed %08h expected 00000002", status);
        end

        // Two back-to-back frames.
        write(8'hA3);
        write(8'h0F);
        idle(2 * FRAME + 5);

        // Six writes: the sixth is dropped and overflow latches.
        for (int i = 1; i <= 6; i++) write(8'(i * 8'h11));
        tests++;
        assert (status[3] === 1'b1) else begin
            fails++;
            $error("FAIL overflow_set: observed %0b expected 1", status[3]);
        end
        // Dropped write and clear together: set wins.
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        tests++;
        assert (status[3] === 1'b1) else begin
            fails++;
            $error("FAIL overflow_set_wins: observed %0b expected 1", status[3]);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        tests++;
        assert (status[3] === 1'b0) else begin
            fails++;
            $error("FAIL overflow_clear: observed %0b expected 0", status[3]);
        end
        idle(5 * FRAME + 5);

        // Reset during data bit 3 with two bytes still queued.
        write(8'h3C);
        write(8'h5A);
        write(8'hC3);
        for (int i = 0; i < 2 * FRAME && !(m_left > 0 && ((FRAME - m_left) / CPB) == 4); i++)
            idle(1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        tests++;
        assert (tx === 1'b1 && status === 32'h0000_0002) else begin
            fails++;
            $error("FAIL midframe_reset: observed tx=%0b status=%08h expected tx=1 status=00000002",
                   tx, status);
        end
        idle(2 * FRAME);

        // Full FIFO, write on the STOP->START pop edge is accepted.
        for (int i = 1; i <= 5; i++) write(8'(i));
        for (int i = 0; i < 2 * FRAME && !(m_left == 1); i++) idle(1);
        write(8'h7E);
        tests++;
        assert (status[0] === 1'b1 && status[3] === 1'b0) else begin
            fails++;
            $error("FAIL pop_edge_write: observed full=%0b ovf=%0b expected full=1 ovf=0",
                   status[0], status[3]);
        end
        idle(5 * FRAME + 5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 5) == 0),
                 8'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        idle(6 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
